// File: rtl/dualram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dualram_pkg : shared types and helpers for the dualram_sdp RAM        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package dualram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   function automatic int addr_w_f(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dualram_clr_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dualram_clr_seq : clear-sweep FSM and pointer for dualram_sdp         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dualram_clr_seq
   import dualram_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = addr_w_f(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (ptr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ONE;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
      // Reset wins over everything and pins the sweep at word 0.
      if (rst) begin
         state_d = ST_CLEAR;
         ptr_d   = '0;
      end
      busy_d = (state_d == ST_CLEAR);
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
   end

   assign busy     = busy_q;
   assign clr_we   = (state_q == ST_CLEAR) && !rst;
   assign clr_addr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/dualram_sdp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dualram_sdp : single-clock simple-dual-port RAM with clear sweep      |
// | Optional macro DUALRAM_BYPASS_EN selects write-first collisions.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dualram_sdp
   import dualram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = addr_w_f(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              clr,
   input  logic              wr_enb,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_enb,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy
);

   logic              seq_busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              port_open;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_acc;
   logic              rd_acc;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_word;

   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   dualram_clr_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .busy     (seq_busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign port_open   = !seq_busy && cs && !rst;
   assign wr_in_range = (int'(wr_addr) < DEPTH);
   assign rd_in_range = (int'(rd_addr) < DEPTH);
   // A clr in the same cycle as a write discards the write.
   assign wr_acc      = port_open && wr_enb && wr_in_range && !clr;
   assign rd_acc      = port_open && rd_enb;

   always_comb begin
      mem_we    = wr_acc;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[rd_addr];
      end
`ifdef DUALRAM_BYPASS_EN
      if (wr_acc && (wr_addr == rd_addr)) begin
         rd_word = wr_data;
      end
`endif
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rst) begin
         rd_data_d = '0;
      end else if (rd_acc) begin
         rd_data_d  = rd_word;
         rd_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = seq_busy;

endmodule
`default_nettype wire

// File: tb/tb_dualram_sdp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dualram_sdp : self-checking bench, DEPTH=16 and DEPTH=12 instances |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dualram_sdp;

`ifdef DUALRAM_BYPASS_EN
   localparam logic [7:0] COLL_EXP = 8'h3C;
`else
   localparam logic [7:0] COLL_EXP = 8'h11;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       cs_a, clr_a, we_a, re_a, rv_a, busy_a;
   logic [3:0] wa_a, ra_a;
   logic [7:0] wd_a, rd_a;
   logic       cs_b, clr_b, we_b, re_b, rv_b, busy_b;
   logic [3:0] wa_b, ra_b;
   logic [7:0] wd_b, rd_b;

   dualram_sdp #(.DATA_W(8), .DEPTH(16)) dut_a (
      .clk(clk), .rst(rst), .cs(cs_a), .clr(clr_a),
      .wr_enb(we_a), .wr_addr(wa_a), .wr_data(wd_a),
      .rd_enb(re_a), .rd_addr(ra_a), .rd_data(rd_a),
      .rd_valid(rv_a), .busy(busy_a)
   );

   dualram_sdp #(.DATA_W(8), .DEPTH(12)) dut_b (
      .clk(clk), .rst(rst), .cs(cs_b), .clr(clr_b),
      .wr_enb(we_b), .wr_addr(wa_b), .wr_data(wd_b),
      .rd_enb(re_b), .rd_addr(ra_b), .rd_data(rd_b),
      .rd_valid(rv_b), .busy(busy_b)
   );

   typedef struct {
      logic       cs;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic       re;
      logic [3:0] ra;
      logic       acc;
      logic [7:0] exp;
   } vec_t;

   vec_t       vt [13];
   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] sb_a [$];
   logic [7:0] sb_b [$];
   logic [7:0] last_a, last_b;
   logic [7:0] model_a [16];
   logic [7:0] model_b [12];
   int         cnt_a, cnt_b;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic setv(input int i, input int cs, input int we, input int wa, input int wd,
                       input int re, input int ra, input int acc, input int exp);
      vt[i].cs  = 1'(cs);
      vt[i].we  = 1'(we);
      vt[i].wa  = 4'(wa);
      vt[i].wd  = 8'(wd);
      vt[i].re  = 1'(re);
      vt[i].ra  = 4'(ra);
      vt[i].acc = 1'(acc);
      vt[i].exp = 8'(exp);
   endtask

   task automatic idle_all();
      cs_a = 0; clr_a = 0; we_a = 0; re_a = 0; wa_a = 0; ra_a = 0; wd_a = 0;
      cs_b = 0; clr_b = 0; we_b = 0; re_b = 0; wa_b = 0; ra_b = 0; wd_b = 0;
   endtask

   // One clock: queue expected read data, then compare what appears after the edge.
   task automatic step(input logic acc_a, input logic [7:0] exp_a,
                       input logic acc_b, input logic [7:0] exp_b);
      logic [7:0] e;
      if (acc_a) sb_a.push_back(exp_a);
      if (acc_b) sb_b.push_back(exp_b);
      @(posedge clk);
      #1;
      chk("rd_valid_a", rv_a, acc_a);
      if (rv_a) begin
         if (sb_a.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_a: rd_valid with no read outstanding, data %0h", rd_a);
         end else begin
            e = sb_a.pop_front();
            chk("rd_data_a", rd_a, e);
            last_a = e;
         end
      end else begin
         chk("hold_a", rd_a, last_a);
      end
      chk("rd_valid_b", rv_b, acc_b);
      if (rv_b) begin
         if (sb_b.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_b: rd_valid with no read outstanding, data %0h", rd_b);
         end else begin
            e = sb_b.pop_front();
            chk("rd_data_b", rd_b, e);
            last_b = e;
         end
      end else begin
         chk("hold_b", rd_b, last_b);
      end
      sb_a.delete();
      sb_b.delete();
   endtask

   task automatic count_busy(output int ca, output int cb);
      ca = 0;
      cb = 0;
      for (int i = 0; i < 40 && (busy_a || busy_b); i++) begin
         ca += int'(busy_a);
         cb += int'(busy_b);
         step(0, 0, 0, 0);
      end
   endtask

   initial begin
      //        cs we wa  wd     re ra acc exp
      setv( 0, 1, 1,  3, 'hA5, 0, 0, 0, 0);
      setv( 1, 1, 0,  0, 0,    1, 3, 1, 'hA5);
      setv( 2, 1, 0,  0, 0,    0, 0, 0, 0);
      setv( 3, 1, 1,  7, 'h11, 0, 0, 0, 0);
      setv( 4, 0, 1,  7, 'h22, 1, 7, 0, 0);
      setv( 5, 1, 0,  0, 0,    1, 7, 1, 'h11);
      setv( 6, 1, 1,  7, 'h3C, 1, 7, 1, int'(COLL_EXP));
      setv( 7, 1, 0,  0, 0,    1, 7, 1, 'h3C);
      setv( 8, 0, 0,  0, 0,    1, 3, 0, 0);
      setv( 9, 1, 1, 15, 'hC3, 1, 0, 1, 0);
      setv(10, 1, 0,  0, 0,    1, 15, 1, 'hC3);
      setv(11, 1, 1,  0, 'h5A, 1, 15, 1, 'hC3);
      setv(12, 1, 0,  0, 0,    1, 0, 1, 'h5A);

      idle_all();
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rd_data", rd_a, 0);
      chk("reset rd_valid", rv_a, 0);
      chk("reset busy_a", busy_a, 1);
      chk("reset busy_b", busy_b, 1);
      last_a = 0;
      last_b = 0;

      rst = 0;
      count_busy(cnt_a, cnt_b);
      chk("busy_len_a", cnt_a, 16);
      chk("busy_len_b", cnt_b, 12);

      for (int i = 0; i < 16; i++) begin
         cs_a = 1; re_a = 1; ra_a = 4'(i);
         step(1, 8'h00, 0, 0);
      end
      idle_all();
      step(0, 0, 0, 0);

      foreach (vt[i]) begin
         cs_a = vt[i].cs; we_a = vt[i].we; wa_a = vt[i].wa; wd_a = vt[i].wd;
         re_a = vt[i].re; ra_a = vt[i].ra;
         step(vt[i].acc, vt[i].exp, 0, 0);
      end
      idle_all();

      for (int i = 0; i < 16; i++) begin
         model_a[i] = 8'(8'h20 + i);
         cs_a = 1; we_a = 1; wa_a = 4'(i); wd_a = model_a[i];
         step(0, 0, 0, 0);
      end
      idle_all();
      cs_a = 1; re_a = 1; ra_a = 4'd9;
      step(1, model_a[9], 0, 0);

      // clr together with a write: the write must vanish in the sweep.
      idle_all();
      cs_a = 1; clr_a = 1; we_a = 1; wa_a = 4'd1; wd_a = 8'h77;
      step(0, 0, 0, 0);
      chk("busy_after_clr", busy_a, 1);
      cnt_a = 1;
      for (int i = 0; i < 40 && busy_a; i++) begin
         idle_all();
         cs_a = 1; we_a = 1; wa_a = 4'd0; wd_a = 8'hFF; re_a = 1; ra_a = 4'd2;
         clr_a = (i == 4);
         step(0, 0, 0, 0);
         if (busy_a) cnt_a++;
      end
      chk("clr_busy_len", cnt_a, 16);
      idle_all();
      for (int i = 0; i < 16; i++) model_a[i] = 8'h00;
      for (int i = 0; i < 16; i++) begin
         cs_a = 1; re_a = 1; ra_a = 4'(i);
         step(1, model_a[i], 0, 0);
      end
      idle_all();

      for (int i = 0; i < 12; i++) model_b[i] = 8'h00;
      model_b[1] = 8'h44;
      cs_b = 1; we_b = 1; wa_b = 4'd1; wd_b = 8'h44;
      step(0, 0, 0, 0);
      wa_b = 4'd13; wd_b = 8'hEE;
      step(0, 0, 0, 0);
      idle_all();
      for (int i = 0; i < 12; i++) begin
         cs_b = 1; re_b = 1; ra_b = 4'(i);
         step(0, 0, 1, model_b[i]);
      end
      ra_b = 4'd13;
      step(0, 0, 1, 8'h00);
      idle_all();

      cs_a = 1; we_a = 1; wa_a = 4'd4; wd_a = 8'h99;
      step(0, 0, 0, 0);
      idle_all();
      cs_a = 1; re_a = 1; ra_a = 4'd4;
      step(1, 8'h99, 0, 0);
      rst = 1;
      last_a = 0;
      last_b = 0;
      step(0, 0, 0, 0);
      rst = 0;
      idle_all();
      repeat (5) step(0, 0, 0, 0);
      chk("mid_sweep_busy", busy_a, 1);
      rst = 1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      rst = 0;
      count_busy(cnt_a, cnt_b);
      chk("restart_busy_len_a", cnt_a, 16);
      chk("restart_busy_len_b", cnt_b, 12);
      cs_a = 1; re_a = 1; ra_a = 4'd4;
      step(1, 8'h00, 0, 0);
      idle_all();
      step(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dualram_sdp.md
# dualram_sdp

Parameterised simple-dual-port RAM with one write port, one registered read port, a self-sequencing clear engine and optional write-to-read bypass. Generalises the team's 16x8 dual RAM to arbitrary width/depth, moves both ports onto a single clock, and replaces the combinational reset with a hardware clear sweep that never loses a cycle of port behaviour silently. Used as the storage core for FIFOs and register files in the datapath.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of words (>=2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cs  in  1  chip select; gates both ports
- clr  in  1  single-cycle pulse request to zero the whole array
- wr_enb  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_enb  in  1  read enable
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated by a read accepted in the previous cycle
- busy  out  1  clear sweep in progress; ports ignored

## Operation
- FSM states: CLEAR, IDLE. rst forces CLEAR with clear pointer = 0; rst held high keeps pointer at 0.
- CLEAR: each cycle writes 0 to ram[ptr], ptr increments; after writing DEPTH-1 -> IDLE. busy = 1 throughout CLEAR.
- IDLE: clr=1 -> CLEAR, ptr=0, starting next cycle; clr while already in CLEAR ignored (sweep not restarted).
- Write accepted when state=IDLE, cs=1, wr_enb=1, wr_addr<DEPTH: ram[wr_addr] <= wr_data at the edge.
- Read accepted when state=IDLE, cs=1, rd_enb=1: rd_data <= ram[rd_addr] (0 if rd_addr>=DEPTH), rd_valid <= 1.
- No accepted read: rd_data holds its value, rd_valid <= 0.
- Write and clr in the same IDLE cycle: write discarded, sweep begins.
- Requests during CLEAR (busy=1) discarded, not queued; caller must hold off on busy.
- Out-of-range write: no storage change. Out-of-range read: rd_data=0, rd_valid=1.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=1 (from the edge where rst is sampled high).
- busy stays high exactly DEPTH cycles after the first edge with rst=0; first port access accepted on edge DEPTH+1.
- clr sampled in IDLE: busy high from the next cycle for DEPTH cycles.
- Read latency: 1 cycle (address at edge N, data/rd_valid valid after edge N).
- Read and write same address same cycle: see Configuration.
- rst asserted mid-sweep or mid-operation: sweep restarts at ptr=0; rd_valid cleared.

## Configuration
- DUALRAM_BYPASS_EN defined: same-cycle read of the address being written returns wr_data (write-first).
- Not defined: same-cycle collision returns the old stored word (read-first); no forwarding mux in the netlist.

## Structure
- Package dualram_pkg: FSM state enum (ST_CLEAR, ST_IDLE) and a clog2-based address-width helper function.
- One sub-module natural: dualram_clr_seq (clear-pointer counter + FSM, outputs busy, clr_we, clr_addr); top muxes its write port between clear engine and user port.

## Test plan
- Reset release, DEPTH=16: busy high exactly 16 cycles, then 0; read every address -> rd_data=0, rd_valid=1 one cycle later.
- Write 0xA5 to addr 3, read addr 3 next cycle -> rd_data=0xA5 one cycle after the read, rd_valid pulse of 1 cycle.
- Same-cycle write 0x3C / read addr 7 holding 0x11 -> 0x3C with DUALRAM_BYPASS_EN, 0x11 without; following read -> 0x3C either way.
- Fill all addresses, pulse clr, issue write 0xFF to addr 0 during busy -> discarded; after sweep all reads return 0.
- DEPTH=12: write addr 13 -> no change anywhere; read addr 13 -> rd_data=0, rd_valid=1.
- Assert rst at sweep cycle 5 for 2 cycles -> busy stays high 16 more cycles after release; cs=0 reads never raise rd_valid.
